// File: rtl/test_vec_streamer_if.sv
// Byte stream link between the vector streamer and its consumer (UART TX / DUT byte port).
// The master drives data/valid and holds them until it sees ready at a clock edge.
interface test_vec_streamer_if;
  localparam int unsigned BYTE_W = 8;

  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface : test_vec_streamer_if

// File: rtl/test_vec_streamer.sv
// Bring-up sequencer: walks test_mem indices 0..NUM_VECS-1, latches each 32-bit word
// and streams it MSB-first as bytes over a valid/ready link, then flags completion.
module test_vec_streamer #(
  parameter int unsigned IDX_W    = 3,
  parameter int unsigned NUM_VECS = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  output logic [IDX_W-1:0]    test_i,
  input  logic [31:0]         test_bits,
  test_vec_streamer_if.master tx_if,
  output logic                busy_o,
  output logic                done_o,
  output logic [IDX_W:0]      vec_count_o
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BIDX_W = 2;
  localparam int unsigned CNT_W  = IDX_W + 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_VECS - 1);
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(WORD_W / BYTE_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e              state_q,     state_d;
  logic [IDX_W-1:0]    test_idx_q,  test_idx_d;
  logic [WORD_W-1:0]   word_q,      word_d;
  logic [BIDX_W-1:0]   byte_idx_q,  byte_idx_d;
  logic [BYTE_W-1:0]   tx_data_q,   tx_data_d;
  logic                tx_valid_q,  tx_valid_d;
  logic [CNT_W-1:0]    vec_count_q, vec_count_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic                xfer_c;

  // Byte i of a word, counting from the most significant byte.
  function automatic logic [BYTE_W-1:0] byte_of(input logic [WORD_W-1:0] w,
                                                input logic [BIDX_W-1:0] i);
    logic [BYTE_W-1:0] b;
    case (i)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  assign xfer_c = tx_valid_q && tx_if.tx_ready;

  // State and datapath registers; async reset clears the link immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      test_idx_q  <= '0;
      word_q      <= '0;
      byte_idx_q  <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      vec_count_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      test_idx_q  <= test_idx_d;
      word_q      <= word_d;
      byte_idx_q  <= byte_idx_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      vec_count_q <= vec_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    test_idx_d  = test_idx_q;
    word_d      = word_q;
    byte_idx_d  = byte_idx_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    vec_count_d = vec_count_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d     = LOAD;
          test_idx_d  = '0;
          vec_count_d = '0;
        end
      end

      // ROM index has been stable since the previous edge, so test_bits is settled here.
      LOAD: begin
        word_d     = test_bits;
        byte_idx_d = '0;
        tx_data_d  = byte_of(test_bits, BIDX_W'(0));
        tx_valid_d = 1'b1;
        state_d    = SEND;
      end

      SEND: begin
        if (xfer_c) begin
          if (byte_idx_q != LAST_BYTE) begin
            byte_idx_d = byte_idx_q + BIDX_W'(1);
            tx_data_d  = byte_of(word_q, byte_idx_q + BIDX_W'(1));
          end else begin
            tx_valid_d  = 1'b0;
            vec_count_d = vec_count_q + CNT_W'(1);
            if (test_idx_q == LAST_IDX) begin
              state_d = DONE;
            end else begin
              test_idx_d = test_idx_q + IDX_W'(1);
              state_d    = LOAD;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags follow the state being entered so they register alongside it.
    busy_d = (state_d == LOAD) || (state_d == SEND);
    done_d = (state_d == DONE);
  end

  assign test_i         = test_idx_q;
  assign tx_if.tx_data  = tx_data_q;
  assign tx_if.tx_valid = tx_valid_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign vec_count_o    = vec_count_q;

endmodule : test_vec_streamer

// File: tb/tb_test_vec_streamer.sv
// Bench for test_vec_streamer: a 7-vector and a 1-vector instance share a ROM model;
// a negedge monitor pops expected bytes from a scoreboard and checks stall stability.
module tb_test_vec_streamer;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned NV    = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic             start7 = 1'b0;
  logic             start1 = 1'b0;
  logic [IDX_W-1:0] idx7, idx1;
  logic [31:0]      bits7, bits1;
  logic             busy7, done7, busy1, done1;
  logic [IDX_W:0]   cnt7, cnt1;

  test_vec_streamer_if if7();
  test_vec_streamer_if if1();

  function automatic logic [31:0] rom(input logic [IDX_W-1:0] a);
    logic [31:0] w;
    case (a)
      3'd0:    w = 32'hFF00_F00F;
      3'd1:    w = 32'h7001_1585;
      3'd2:    w = 32'h0000_0000;
      3'd3:    w = 32'h1234_5678;
      3'd4:    w = 32'hA5C3_3C5A;
      3'd5:    w = 32'hDEAD_BEEF;
      3'd6:    w = 32'h0F06_00F0;
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  assign bits7 = rom(idx7);
  assign bits1 = rom(idx1);

  test_vec_streamer #(.IDX_W(IDX_W), .NUM_VECS(NV)) dut7 (
    .clk(clk), .rst_n(rst_n), .start_i(start7), .test_i(idx7), .test_bits(bits7),
    .tx_if(if7.master), .busy_o(busy7), .done_o(done7), .vec_count_o(cnt7)
  );

  test_vec_streamer #(.IDX_W(IDX_W), .NUM_VECS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .test_i(idx1), .test_bits(bits1),
    .tx_if(if1.master), .busy_o(busy1), .done_o(done1), .vec_count_o(cnt1)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  logic [7:0] sb_q[$];
  int         rx_count = 0;
  logic       stall_pending = 1'b0;
  logic [7:0] stall_data = 8'h00;

  task automatic push_stream(input int nv);
    logic [31:0] w;
    for (int v = 0; v < nv; v++) begin
      w = rom(IDX_W'(v));
      for (int b = 3; b >= 0; b--) sb_q.push_back(w[b*8 +: 8]);
    end
  endtask

  // Ready pattern: 0 = tied high, 1 = random ~30% high, 2 = high one cycle in three.
  int ready_mode = 0;
  int ph = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: if7.tx_ready = ($urandom_range(99) < 30);
      2: begin
        if7.tx_ready = (ph == 2);
        ph = (ph == 2) ? 0 : ph + 1;
      end
      default: if7.tx_ready = 1'b1;
    endcase
  end

  // Monitor: a transfer is valid&&ready seen here, completing at the next posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pending = 1'b0;
    end else begin
      if (stall_pending) begin
        check("stall_valid_hold", 32'(if7.tx_valid), 32'd1);
        check("stall_data_hold", 32'(if7.tx_data), 32'(stall_data));
        stall_pending = 1'b0;
      end
      if (if7.tx_valid === 1'b1) begin
        if (if7.tx_ready === 1'b1) begin
          check("sb_has_entry", 32'(sb_q.size() > 0), 32'd1);
          if (sb_q.size() > 0) check("sb_byte", 32'(if7.tx_data), 32'(sb_q.pop_front()));
          rx_count++;
        end else begin
          stall_pending = 1'b1;
          stall_data    = if7.tx_data;
        end
      end
    end
  end

  typedef struct {
    int             ready_mode;
    bit             mid_start;
    int             exp_cycles;   // -1: latency not fixed under this ready pattern
    logic [IDX_W:0] exp_cnt;
    int             exp_bytes;
  } run_t;

  run_t       runs[4];
  bit         hit;
  int         cycles;
  int         got_n;
  logic [7:0] got[4];
  logic [31:0] w0;

  initial begin
    runs[0] = '{0, 1'b0, 35, 4'd7, 28};
    runs[1] = '{1, 1'b0, -1, 4'd7, 28};
    runs[2] = '{0, 1'b1, 35, 4'd7, 28};
    runs[3] = '{2, 1'b0, -1, 4'd7, 28};
    if1.tx_ready = 1'b1;

    // Reset state.
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(if7.tx_valid), 32'd0);
    check("rst_data", 32'(if7.tx_data), 32'd0);
    check("rst_busy", 32'(busy7), 32'd0);
    check("rst_done", 32'(done7), 32'd0);
    check("rst_idx", 32'(idx7), 32'd0);
    check("rst_cnt", 32'(cnt7), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int r = 0; r < 4; r++) begin
      ready_mode = runs[r].ready_mode;
      rx_count   = 0;
      @(posedge clk);
      #1;
      start7 = 1'b1;
      push_stream(NV);
      hit = 1'b0;
      cycles = 0;
      for (int c = 0; c < 3000; c++) begin
        @(posedge clk);
        #1;
        if (c == 0) begin
          start7 = 1'b0;
          check("start_busy", 32'(busy7), 32'd1);
          check("start_done_low", 32'(done7), 32'd0);
          check("start_idx", 32'(idx7), 32'd0);
          check("start_cnt", 32'(cnt7), 32'd0);
        end
        if (runs[r].mid_start) begin
          if (c == 12) start7 = 1'b1;
          else if (c == 13) start7 = 1'b0;
        end
        check("busy_done_excl", 32'(busy7 & done7), 32'd0);
        check("idx_range", 32'(idx7 <= 3'(NV - 1)), 32'd1);
        if (done7) begin
          cycles = c;
          hit = 1'b1;
          break;
        end
      end
      check("done_reached", 32'(hit), 32'd1);
      if (runs[r].exp_cycles >= 0) check("done_latency", 32'(cycles), 32'(runs[r].exp_cycles));
      check("end_cnt", 32'(cnt7), 32'(runs[r].exp_cnt));
      check("end_idx", 32'(idx7), 32'(NV - 1));
      check("end_bytes", 32'(rx_count), 32'(runs[r].exp_bytes));
      check("end_sb_empty", 32'(sb_q.size()), 32'd0);
      check("end_busy", 32'(busy7), 32'd0);
      check("end_valid", 32'(if7.tx_valid), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("done_holds", 32'(done7), 32'd1);
    end

    // Reset during byte 2 of vector 3.
    ready_mode = 0;
    @(posedge clk);
    #1;
    start7 = 1'b1;
    push_stream(NV);
    for (int c = 0; c <= 18; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) start7 = 1'b0;
    end
    w0 = rom(3'd3);
    check("pre_rst_idx", 32'(idx7), 32'd3);
    check("pre_rst_byte2", 32'(if7.tx_data), 32'(w0[15:8]));
    check("pre_rst_valid", 32'(if7.tx_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(if7.tx_valid), 32'd0);
    check("async_rst_data", 32'(if7.tx_data), 32'd0);
    check("async_rst_busy", 32'(busy7), 32'd0);
    check("async_rst_cnt", 32'(cnt7), 32'd0);
    check("async_rst_idx", 32'(idx7), 32'd0);
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_valid", 32'(if7.tx_valid), 32'd0);
    check("post_rst_busy", 32'(busy7), 32'd0);
    check("post_rst_done", 32'(done7), 32'd0);

    // Single-vector instance.
    @(posedge clk);
    #1;
    start1 = 1'b1;
    got_n = 0;
    hit = 1'b0;
    cycles = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) start1 = 1'b0;
      if (if1.tx_valid) begin
        if (got_n < 4) got[got_n] = if1.tx_data;
        got_n++;
      end
      if (done1) begin
        cycles = c;
        hit = 1'b1;
        break;
      end
    end
    w0 = rom(3'd0);
    check("nv1_done_reached", 32'(hit), 32'd1);
    check("nv1_latency", 32'(cycles), 32'd5);
    check("nv1_bytes", 32'(got_n), 32'd4);
    for (int b = 0; b < 4; b++) check("nv1_byte", 32'(got[b]), 32'(w0[(3-b)*8 +: 8]));
    check("nv1_cnt", 32'(cnt1), 32'd1);
    check("nv1_idx", 32'(idx1), 32'd0);
    check("nv1_busy", 32'(busy1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule : tb_test_vec_streamer
